// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: queue entry layout,
// instruction size in bytes and the bubble instruction shown when the queue is empty.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch buffer: DEPTH entries held in registers so the head entry
// is readable in the same cycle it is stored. Flush empties it in one cycle.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_pop;

  assign do_pop    = pop & ~empty;
  assign count     = count_reg;
  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign head_data = mem[rd_ptr_reg];

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge CLK) begin
    if (!RESET_N || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)   wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch producer: credit-limited sequential requests, in-order prefetch queue,
// redirect squash. Define FETCH_PERF_CNT_EN to add StallCnt/SquashCnt outputs.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              SIZE     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [SIZE-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            StallF,
  input  logic            BranchE,
  input  logic [SIZE-1:0] TargetE,
  output logic            ImemReq,
  output logic [SIZE-1:0] ImemAddr,
  input  logic            ImemGnt,
  input  logic            ImemRValid,
  input  logic [SIZE-1:0] ImemRData,
  output logic [SIZE-1:0] InstrF,
  output logic [SIZE-1:0] PCF,
  output logic            ValidF
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     StallCnt,
  output logic [31:0]     SquashCnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [SIZE-1:0]   pc_reg, pc_next;
  logic [SIZE-1:0]   resp_pc_reg, resp_pc_next;
  logic [CW-1:0]     outstanding_reg, outstanding_next;
  logic [CW-1:0]     discard_reg, discard_next;
  logic [CW-1:0]     occupancy;
  logic [CW:0]       credit_used;
  logic [2*SIZE-1:0] head_data;
  logic              fifo_full, fifo_empty;
  logic              fire, push, pop;
  logic [SIZE-1:0]   target_aligned;
  logic              target_lsb_unused;

  assign target_aligned    = {TargetE[SIZE-1:2], 2'b00};
  assign target_lsb_unused = ^TargetE[1:0];

  // Buffered plus in-flight words never exceed DEPTH, so a response always has a slot.
  assign credit_used = {1'b0, occupancy} + {1'b0, outstanding_reg};
  assign ImemReq  = RESET_N && (credit_used < (CW+1)'(DEPTH)) && !BranchE && (discard_reg == '0);
  assign ImemAddr = pc_reg;
  assign fire     = ImemReq & ImemGnt;
  assign push     = ImemRValid & ~BranchE & (discard_reg == '0);
  assign pop      = ValidF & ~StallF & ~BranchE;

  assign ValidF = ~fifo_empty;
  assign InstrF = fifo_empty ? SIZE'(NOP_INSTR) : head_data[2*SIZE-1:SIZE];
  assign PCF    = fifo_empty ? '0 : head_data[SIZE-1:0];

  fetch_fifo #(.WIDTH(2*SIZE), .DEPTH(DEPTH)) u_fifo (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .flush     (BranchE),
    .push      (push),
    .push_data ({ImemRData, resp_pc_reg}),
    .pop       (pop),
    .head_data (head_data),
    .count     (occupancy),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // resp_pc tracks the address of the next kept response: responses are in
  // order, and every kept one follows the last redirect target sequentially.
  always_comb begin
    pc_next          = pc_reg;
    resp_pc_next     = resp_pc_reg;
    outstanding_next = outstanding_reg + CW'(fire) - CW'(ImemRValid);
    discard_next     = discard_reg;
    if (BranchE) begin
      pc_next      = target_aligned;
      resp_pc_next = target_aligned;
      discard_next = outstanding_reg + CW'(fire) - CW'(ImemRValid);
    end else begin
      if (fire) pc_next = pc_reg + SIZE'(INSTR_BYTES);
      if (ImemRValid) begin
        if (discard_reg != '0) discard_next = discard_reg - CW'(1);
        else                   resp_pc_next = resp_pc_reg + SIZE'(INSTR_BYTES);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      pc_reg          <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else begin
      pc_reg          <= pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
    end
  end

  a_no_overflow: assert property (@(posedge CLK) disable iff (!RESET_N) !(push && fifo_full));

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_reg, squash_cnt_reg;
  logic [CW:0] squash_inc;
  logic [32:0] squash_sum;

  // Squashed work: valid entries flushed by a redirect plus each dropped response.
  assign squash_inc = (BranchE ? {1'b0, occupancy} : '0)
                    + (CW+1)'(ImemRValid && (BranchE || discard_reg != '0));
  assign squash_sum = {1'b0, squash_cnt_reg} + 33'(squash_inc);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      stall_cnt_reg  <= '0;
      squash_cnt_reg <= '0;
    end else begin
      if (ValidF && StallF && stall_cnt_reg != '1) stall_cnt_reg <= stall_cnt_reg + 32'd1;
      squash_cnt_reg <= squash_sum[32] ? '1 : squash_sum[31:0];
    end
  end

  assign StallCnt  = stall_cnt_reg;
  assign SquashCnt = squash_cnt_reg;
`endif

endmodule
